// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_unit
//  Purpose  : IF stage. Fetch PC, single-outstanding imem handshake, fetch
//             queue and IF/ID pipeline register with stall/redirect handling.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [31:0] instruction,
  output logic [63:0] PC_out_IF_ID,
  output logic        valid_IF_ID
);

  localparam logic [31:0]     c_NOP    = 32'hD503201F;
  localparam int              c_PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int              c_CW     = $clog2(QDEPTH + 1);
  localparam logic [c_CW-1:0] c_QDEPTH = c_CW'(QDEPTH);
  localparam logic [c_PW-1:0] c_LAST   = c_PW'(QDEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          r_state;
  logic [63:0]     r_fetch_pc;
  logic            r_imem_req;
  logic [63:0]     r_imem_addr;

  logic [63:0]     r_q_pc    [QDEPTH];
  logic [31:0]     r_q_instr [QDEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;

  logic [31:0]     r_instr;
  logic [63:0]     r_pc_if_id;
  logic            r_valid;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [c_CW-1:0] w_count_next;
  logic            w_room;
  logic [63:0]     w_target;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // r_imem_req is only ever high in S_REQ, so it doubles as the state qualifier.
  assign w_accept     = r_imem_req & imem_ready;
  assign w_push       = (r_state == S_WAIT) & imem_rvalid & ~branch_taken;
  assign w_pop        = ~branch_taken & ~stall & (r_count != '0);
  assign w_count_next = r_count + c_CW'(w_push) - c_CW'(w_pop);
  assign w_room       = (w_count_next < c_QDEPTH);
  assign w_target     = branch_target & ~64'h3;

  // Fetch FSM; a new request is only launched when the queue can absorb it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!branch_taken && w_room) begin
            r_state     <= S_REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (branch_taken) begin
            r_state    <= w_accept ? S_DROP : S_IDLE;
            r_imem_req <= 1'b0;
          end else if (w_accept) begin
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
            r_fetch_pc <= r_fetch_pc + 64'd4;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!branch_taken && w_room) begin
              r_state     <= S_REQ;
              r_imem_req  <= 1'b1;
              r_imem_addr <= r_fetch_pc;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (branch_taken) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (branch_taken) begin
        r_fetch_pc <= w_target;
      end
    end
  end

  // Queue storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_pc[r_tail]    <= r_imem_addr;
      r_q_instr[r_tail] <= imem_rdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (branch_taken) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= f_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= f_inc(r_head);
      end
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr    <= c_NOP;
      r_pc_if_id <= 64'd0;
      r_valid    <= 1'b0;
    end else if (branch_taken) begin
      r_instr    <= c_NOP;
      r_pc_if_id <= 64'd0;
      r_valid    <= 1'b0;
    end else if (!stall) begin
      if (w_pop) begin
        r_instr    <= r_q_instr[r_head];
        r_pc_if_id <= r_q_pc[r_head];
        r_valid    <= 1'b1;
      end else begin
        r_instr    <= c_NOP;
        r_pc_if_id <= 64'd0;
        r_valid    <= 1'b0;
      end
    end
  end

  // The reserved slot guarantees room for every response that arrives.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !((r_state == S_WAIT) && imem_rvalid && (r_count == c_QDEPTH)));

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_imem_addr;
  assign instruction  = r_instr;
  assign PC_out_IF_ID = r_pc_if_id;
  assign valid_IF_ID  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch_unit
//  Purpose  : Directed + random bench for instruction_fetch_unit against a
//             memory model and an in-order fetch-stream reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [63:0] c_RESET_PC = 64'h100;
  localparam logic [31:0] c_NOP      = 32'hD503201F;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] instruction;
  logic [63:0] PC_out_IF_ID;
  logic        valid_IF_ID;

  instruction_fetch_unit #(.RESET_PC(c_RESET_PC), .QDEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instruction  (instruction),
    .PC_out_IF_ID (PC_out_IF_ID),
    .valid_IF_ID  (valid_IF_ID)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          total;
  int          bad;
  int          n_deliv;
  int          ready_mode;
  int          lat_lo;
  int          lat_hi;
  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;
  bit          accepted_last;
  logic [63:0] exp_pc;
  logic [63:0] exp_fetch;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, advance, update memory model and fetch reference.
  task automatic step(input bit st, input bit br, input logic [63:0] tgt);
    bit          acc;
    bit          rv;
    logic        req_pre;
    logic [63:0] addr_pre;
    logic [31:0] ins_pre;
    logic [63:0] pc_pre;
    logic        v_pre;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    case (ready_mode)
      0:       imem_ready = 1'b1;
      1:       imem_ready = ($urandom_range(0, 3) != 0);
      default: imem_ready = 1'b0;
    endcase
    rv          = mem_busy && (mem_cnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? memf(mem_addr) : $urandom;
    req_pre  = imem_req;
    addr_pre = imem_addr;
    acc      = imem_req && imem_ready;
    ins_pre  = instruction;
    pc_pre   = PC_out_IF_ID;
    v_pre    = valid_IF_ID;
    @(posedge clock);
    #1;
    accepted_last = acc;
    if (acc) begin
      chk("one_outstanding", 64'(mem_busy && !rv), 64'd0);
      chk("req_addr", addr_pre, exp_fetch);
      exp_fetch = exp_fetch + 64'd4;
    end
    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (acc) begin
      mem_busy = 1'b1;
      mem_addr = addr_pre;
      mem_cnt  = int'($urandom_range(lat_lo, lat_hi)) - 1;
    end
    if (req_pre && !imem_ready && !br) begin
      chk("req_hold", 64'(imem_req), 64'd1);
      chk("addr_hold", imem_addr, addr_pre);
    end
    if (br) begin
      chk("br_valid", 64'(valid_IF_ID), 64'd0);
      chk("br_instr", 64'(instruction), 64'(c_NOP));
      exp_pc    = {tgt[63:2], 2'b00};
      exp_fetch = {tgt[63:2], 2'b00};
    end else if (st) begin
      chk("stall_instr", 64'(instruction), 64'(ins_pre));
      chk("stall_pc", PC_out_IF_ID, pc_pre);
      chk("stall_valid", 64'(valid_IF_ID), 64'(v_pre));
    end else if (valid_IF_ID) begin
      chk("pc_order", PC_out_IF_ID, exp_pc);
      chk("instr_data", 64'(instruction), 64'(memf(exp_pc)));
      exp_pc = exp_pc + 64'd4;
      n_deliv++;
    end else begin
      chk("bubble_instr", 64'(instruction), 64'(c_NOP));
      chk("bubble_pc", PC_out_IF_ID, 64'd0);
    end
  endtask

  initial begin
    int start;
    total = 0; bad = 0; n_deliv = 0;
    ready_mode = 0; lat_lo = 1; lat_hi = 1;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = 64'd0; accepted_last = 1'b0;
    exp_pc = c_RESET_PC; exp_fetch = c_RESET_PC;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, c_RESET_PC);
    chk("rst_instr", 64'(instruction), 64'(c_NOP));
    chk("rst_pc", PC_out_IF_ID, 64'd0);
    chk("rst_valid", 64'(valid_IF_ID), 64'd0);
    reset = 1'b0;

    // Zero-wait memory: first fetch timing and first three PCs
    step(0, 0, 64'd0);
    chk("a_req1", 64'(imem_req), 64'd1);
    chk("a_addr1", imem_addr, 64'h100);
    step(0, 0, 64'd0);
    chk("a_wait_req", 64'(imem_req), 64'd0);
    step(0, 0, 64'd0);
    chk("a_req2", 64'(imem_req), 64'd1);
    chk("a_addr2", imem_addr, 64'h104);
    chk("a_no_bypass", 64'(valid_IF_ID), 64'd0);
    step(0, 0, 64'd0);
    chk("a_first_valid", 64'(valid_IF_ID), 64'd1);
    chk("a_first_pc", PC_out_IF_ID, 64'h100);
    for (int i = 0; i < 40 && n_deliv < 3; i++) step(0, 0, 64'd0);
    chk("a_three", 64'(n_deliv), 64'd3);

    // Long stall: IF/ID frozen, queue fills, requests stop, then resume in order
    for (int i = 0; i < 30 && !valid_IF_ID; i++) step(0, 0, 64'd0);
    for (int i = 0; i < 8; i++) step(1, 0, 64'd0);
    chk("b_req_idle", 64'(imem_req), 64'd0);
    step(0, 0, 64'd0);
    chk("b_resume0", 64'(valid_IF_ID), 64'd1);
    step(0, 0, 64'd0);
    chk("b_resume1", 64'(valid_IF_ID), 64'd1);

    // Redirect to 0x2002 while waiting on a response
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 64'd0);
      if (accepted_last) break;
    end
    chk("c_acc", 64'(accepted_last), 64'd1);
    step(0, 1, 64'h2002);
    chk("c_req_off", 64'(imem_req), 64'd0);
    for (int i = 0; i < 20 && !imem_req; i++) step(0, 0, 64'd0);
    chk("c_new_addr", imem_addr, 64'h2000);

    // Redirect and stall in the same cycle
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 30 && !valid_IF_ID; i++) step(0, 0, 64'd0);
    step(1, 1, 64'h3000);
    for (int i = 0; i < 20 && !imem_req; i++) step(0, 0, 64'd0);
    chk("d_new_addr", imem_addr, 64'h3000);

    // Memory not ready for 4 cycles, fetch PC wraps past 2^64
    ready_mode = 2;
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 20 && !imem_req; i++) step(0, 0, 64'd0);
    chk("e_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 4; i++) step(0, 0, 64'd0);
    chk("e_req_held", 64'(imem_req), 64'd1);
    ready_mode = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 64'd0);
      if (accepted_last) break;
    end
    for (int i = 0; i < 10 && !imem_req; i++) step(0, 0, 64'd0);
    chk("e_wrap_addr", imem_addr, 64'd0);

    // Reset while a request is outstanding; the late response must be ignored
    lat_lo = 4; lat_hi = 4;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 64'd0);
      if (accepted_last) break;
    end
    chk("f_acc", 64'(accepted_last), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("f_rst_req", 64'(imem_req), 64'd0);
    chk("f_rst_addr", imem_addr, c_RESET_PC);
    chk("f_rst_instr", 64'(instruction), 64'(c_NOP));
    chk("f_rst_pc", PC_out_IF_ID, 64'd0);
    chk("f_rst_valid", 64'(valid_IF_ID), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_cnt = 0;
    exp_pc = c_RESET_PC;
    exp_fetch = c_RESET_PC;
    lat_lo = 1; lat_hi = 3;
    step(0, 0, 64'd0);
    chk("f_req_after", 64'(imem_req), 64'd1);
    chk("f_addr_after", imem_addr, c_RESET_PC);

    // Random stall / redirect / ready / latency traffic
    ready_mode = 1;
    for (int i = 0; i < 500; i++) begin
      bit          st;
      bit          br;
      logic [63:0] tgt;
      st  = ($urandom_range(0, 99) < 20);
      br  = ($urandom_range(0, 99) < 4);
      tgt = {($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'h0, $urandom};
      step(st, br, tgt);
    end

    // Quiet drain: the stream must keep flowing
    ready_mode = 0;
    start = n_deliv;
    for (int i = 0; i < 60; i++) step(0, 0, 64'd0);
    chk("drain_progress", 64'((n_deliv - start) >= 10), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
